// File: rtl/am9514_sched_pkg.sv
// Shared types and ring-address helper for the CAI job sequencer.
package am9514_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WCOMP,
      DOORBELL
   } sched_state_e;

   localparam int unsigned DESC_BYTES_DEF = 64;
   localparam int unsigned COMP_BYTES_DEF = 16;

   // Strides are powers of two, so the multiply collapses to a shift.
   function automatic logic [63:0] ring_addr(input logic [63:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] mask,
                                             input int unsigned stride_log2);
      logic [63:0] off;
      off = {32'd0, idx & mask} << stride_log2;
      return base + off;
   endfunction

endpackage

// File: rtl/cai_ring_ptr.sv
// Free-running 32-bit ring index with a registered, masked byte address.
module cai_ring_ptr
   import am9514_sched_pkg::*;
#(
   parameter int unsigned STRIDE_LOG2 = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        hold,
   input  logic [63:0] base,
   input  logic [31:0] mask,
   output logic [63:0] addr
);

   logic [31:0] idx;

   // addr is frozen while the consumer holds a request open on it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         addr <= '0;
      end else begin
         if (advance) idx <= idx + 32'd1;
         if (!hold) addr <= ring_addr(base, idx, mask, STRIDE_LOG2);
      end
   end

endmodule

// File: rtl/am9514_cai_sched.sv
// In-order job sequencer: submit doorbells -> descriptor fetch -> engine ->
// completion write -> completion doorbell / irq.
//
// state    | meaning
// IDLE     | waiting for enable and a pending descriptor
// FETCH    | descriptor fetch request held until fetch_ready
// EXEC     | engine running the job, waiting for exec_done
// WCOMP    | completion-record write held until cwr_ready
// DOORBELL | one-cycle completion doorbell, irq set if enabled
module am9514_cai_sched
   import am9514_sched_pkg::*;
#(
   parameter int unsigned DESC_BYTES = DESC_BYTES_DEF,
   parameter int unsigned COMP_BYTES = COMP_BYTES_DEF,
   parameter int unsigned PEND_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              submit_doorbell,
   input  logic [63:0]       submit_desc_base,
   input  logic [31:0]       submit_ring_mask,
   input  logic [63:0]       comp_base,
   input  logic [31:0]       comp_ring_mask,
   input  logic              irq_enable,
   input  logic              irq_clr,
   output logic              fetch_valid,
   output logic [63:0]       fetch_addr,
   input  logic              fetch_ready,
   input  logic              exec_done,
   input  logic [15:0]       exec_status,
   output logic              cwr_valid,
   output logic [63:0]       cwr_addr,
   input  logic              cwr_ready,
   output logic              comp_doorbell,
   output logic              irq,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow,
   output logic [15:0]       err_count
);

   localparam int unsigned DESC_LOG2 = $clog2(DESC_BYTES);
   localparam int unsigned COMP_LOG2 = $clog2(COMP_BYTES);

   sched_state_e state, state_n;
   logic         fetch_hs;
   logic         cwr_hs;
   logic [32:0]  ring_cap;
   logic         pend_full;

   assign fetch_hs  = fetch_valid & fetch_ready;
   assign cwr_hs    = cwr_valid & cwr_ready;
   assign ring_cap  = {1'b0, submit_ring_mask} + 33'd1;
   assign pend_full = (33'(pending) == ring_cap) || (pending == {PEND_W{1'b1}});
   assign busy      = (state != IDLE);

   cai_ring_ptr #(.STRIDE_LOG2(DESC_LOG2)) u_submit_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (fetch_hs),
      .hold    (fetch_valid),
      .base    (submit_desc_base),
      .mask    (submit_ring_mask),
      .addr    (fetch_addr)
   );

   cai_ring_ptr #(.STRIDE_LOG2(COMP_LOG2)) u_comp_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (cwr_hs),
      .hold    (cwr_valid),
      .base    (comp_base),
      .mask    (comp_ring_mask),
      .addr    (cwr_addr)
   );

   // A doorbell coinciding with a fetch handshake nets to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else if (submit_doorbell && !fetch_hs) begin
         if (pend_full) overflow <= 1'b1;
         else pending <= pending + PEND_W'(1);
      end else if (!submit_doorbell && fetch_hs) begin
         pending <= pending - PEND_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n       = state;
      fetch_valid   = 1'b0;
      cwr_valid     = 1'b0;
      comp_doorbell = 1'b0;
      unique case (state)
         IDLE:     if (enable && (pending != '0)) state_n = FETCH;
         FETCH: begin
            fetch_valid = 1'b1;
            if (fetch_ready) state_n = EXEC;
         end
         EXEC:     if (exec_done) state_n = WCOMP;
         WCOMP: begin
            cwr_valid = 1'b1;
            if (cwr_ready) state_n = DOORBELL;
         end
         DOORBELL: begin
            comp_doorbell = 1'b1;
            state_n       = IDLE;
         end
         default:  state_n = IDLE;
      endcase
   end

   // Set has priority over clear so a completion is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq       <= 1'b0;
         err_count <= '0;
      end else begin
         if (state == DOORBELL && irq_enable) irq <= 1'b1;
         else if (irq_clr) irq <= 1'b0;
         if (state == EXEC && exec_done && exec_status != 16'd0 && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_am9514_cai_sched.sv
// Directed bench for am9514_cai_sched: job table plus hand-written corner sequences.
module tb_am9514_cai_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        submit_doorbell;
   logic [63:0] submit_desc_base;
   logic [31:0] submit_ring_mask;
   logic [63:0] comp_base;
   logic [31:0] comp_ring_mask;
   logic        irq_enable;
   logic        irq_clr;
   logic        fetch_valid;
   logic [63:0] fetch_addr;
   logic        fetch_ready;
   logic        exec_done;
   logic [15:0] exec_status;
   logic        cwr_valid;
   logic [63:0] cwr_addr;
   logic        cwr_ready;
   logic        comp_doorbell;
   logic        irq;
   logic        busy;
   logic [15:0] pending;
   logic        overflow;
   logic [15:0] err_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   am9514_cai_sched dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .submit_doorbell  (submit_doorbell),
      .submit_desc_base (submit_desc_base),
      .submit_ring_mask (submit_ring_mask),
      .comp_base        (comp_base),
      .comp_ring_mask   (comp_ring_mask),
      .irq_enable       (irq_enable),
      .irq_clr          (irq_clr),
      .fetch_valid      (fetch_valid),
      .fetch_addr       (fetch_addr),
      .fetch_ready      (fetch_ready),
      .exec_done        (exec_done),
      .exec_status      (exec_status),
      .cwr_valid        (cwr_valid),
      .cwr_addr         (cwr_addr),
      .cwr_ready        (cwr_ready),
      .comp_doorbell    (comp_doorbell),
      .irq              (irq),
      .busy             (busy),
      .pending          (pending),
      .overflow         (overflow),
      .err_count        (err_count)
   );

   typedef struct {
      int          fdly;
      logic [15:0] st;
      bit          spur;
      logic [63:0] fa;
      logic [63:0] ca;
      logic [15:0] err;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic ring();
      submit_doorbell = 1'b1;
      @(negedge clk);
      submit_doorbell = 1'b0;
   endtask

   // Services one job; called and returns at a negedge.
   task automatic run_job(input int fdly, input logic [15:0] st, input bit spur,
                          input bit db_with_hs, input bit clr_at_db,
                          output logic [63:0] fa, output logic [63:0] ca,
                          output int ndb, output logic [15:0] pend_hs);
      int t;
      fa = '0; ca = '0; ndb = 0; pend_hs = '0;
      t = 0;
      while (!fetch_valid && t < 40) begin @(negedge clk); t++; end
      if (!fetch_valid) begin
         checks++; failures++;
         $display("FAIL fetch_timeout actual=0 required=1");
         return;
      end
      fa = fetch_addr;
      for (int i = 0; i < fdly; i++) begin
         if (spur && i == 0) begin exec_done = 1'b1; exec_status = 16'h00ff; end
         @(negedge clk);
         exec_done = 1'b0; exec_status = 16'h0;
      end
      if (fdly > 0) chk("fetch_addr_stable", fetch_addr, fa);
      fetch_ready = 1'b1;
      if (db_with_hs) submit_doorbell = 1'b1;
      @(negedge clk);
      fetch_ready = 1'b0; submit_doorbell = 1'b0;
      pend_hs = pending;
      exec_done = 1'b1; exec_status = st;
      @(negedge clk);
      exec_done = 1'b0; exec_status = 16'h0;
      t = 0;
      while (!cwr_valid && t < 40) begin @(negedge clk); t++; end
      if (!cwr_valid) begin
         checks++; failures++;
         $display("FAIL cwr_timeout actual=0 required=1");
         return;
      end
      ca = cwr_addr;
      cwr_ready = 1'b1;
      @(negedge clk);
      cwr_ready = 1'b0;
      if (clr_at_db) irq_clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (comp_doorbell) ndb++;
         @(negedge clk);
         irq_clr = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] fa, ca;
      logic [15:0] ph;
      int ndb, tot, t;

      vt[0]  = '{0, 16'h0000, 1'b0, 64'h140, 64'h510, 16'd0};
      vt[1]  = '{1, 16'h0000, 1'b0, 64'h180, 64'h520, 16'd0};
      vt[2]  = '{0, 16'h0003, 1'b0, 64'h1C0, 64'h530, 16'd1};
      vt[3]  = '{2, 16'h0000, 1'b0, 64'h200, 64'h540, 16'd1};
      vt[4]  = '{2, 16'h0000, 1'b1, 64'h240, 64'h550, 16'd1};
      vt[5]  = '{0, 16'h0000, 1'b0, 64'h280, 64'h560, 16'd1};
      vt[6]  = '{3, 16'h0000, 1'b0, 64'h2C0, 64'h570, 16'd1};
      vt[7]  = '{0, 16'h0000, 1'b0, 64'h300, 64'h580, 16'd1};
      vt[8]  = '{1, 16'h0000, 1'b0, 64'h340, 64'h590, 16'd1};
      vt[9]  = '{0, 16'h8000, 1'b0, 64'h380, 64'h5A0, 16'd2};
      vt[10] = '{0, 16'h0000, 1'b0, 64'h3C0, 64'h5B0, 16'd2};
      vt[11] = '{1, 16'h0000, 1'b1, 64'h400, 64'h5C0, 16'd2};
      vt[12] = '{0, 16'h0000, 1'b0, 64'h440, 64'h5D0, 16'd2};
      vt[13] = '{0, 16'h0000, 1'b0, 64'h480, 64'h5E0, 16'd2};
      vt[14] = '{2, 16'h0000, 1'b0, 64'h4C0, 64'h5F0, 16'd2};
      vt[15] = '{0, 16'h0000, 1'b0, 64'h100, 64'h500, 16'd2};

      rst = 1'b1; enable = 1'b0; submit_doorbell = 1'b0;
      submit_desc_base = 64'h100; submit_ring_mask = 32'd15;
      comp_base = 64'h500; comp_ring_mask = 32'd15;
      irq_enable = 1'b0; irq_clr = 1'b0; fetch_ready = 1'b0;
      exec_done = 1'b0; exec_status = 16'h0; cwr_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_fetch_addr", fetch_addr, 0);
      chk("rst_cwr_addr", cwr_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // basic job with latency check
      enable = 1'b1;
      ring();
      chk("lat_pending", pending, 1);
      chk("lat_fetch_valid_n1", fetch_valid, 0);
      @(negedge clk);
      chk("lat_fetch_valid_n2", fetch_valid, 1);
      run_job(2, 16'h0, 1'b0, 1'b0, 1'b0, fa, ca, ndb, ph);
      chk("basic_fetch_addr", fa, 64'h100);
      chk("basic_cwr_addr", ca, 64'h500);
      chk("basic_doorbells", ndb, 1);
      chk("basic_pending", pending, 0);
      chk("basic_irq", irq, 0);

      // table: jobs 2..17, wraps back to ring slot 0
      for (int k = 0; k < 16; k++) begin
         ring();
         run_job(vt[k].fdly, vt[k].st, vt[k].spur, 1'b0, 1'b0, fa, ca, ndb, ph);
         chk($sformatf("tbl%0d_fetch_addr", k), fa, vt[k].fa);
         chk($sformatf("tbl%0d_cwr_addr", k), ca, vt[k].ca);
         chk($sformatf("tbl%0d_doorbells", k), ndb, 1);
         chk($sformatf("tbl%0d_err_count", k), err_count, vt[k].err);
         chk($sformatf("tbl%0d_pending", k), pending, 0);
      end

      // burst to ring capacity, then one dropped doorbell
      enable = 1'b0;
      for (int i = 0; i < 16; i++) ring();
      chk("burst_pending", pending, 16);
      chk("burst_overflow_pre", overflow, 0);
      ring();
      chk("ovf_pending", pending, 16);
      chk("ovf_overflow", overflow, 1);
      chk("ovf_busy", busy, 0);
      enable = 1'b1;
      tot = 0;
      for (int k = 0; k < 16; k++) begin
         run_job(0, 16'h0, 1'b0, 1'b0, 1'b0, fa, ca, ndb, ph);
         chk($sformatf("burst%0d_fetch_addr", k), fa, vt[k].fa);
         chk($sformatf("burst%0d_cwr_addr", k), ca, vt[k].ca);
         tot += ndb;
      end
      repeat (3) @(negedge clk);
      chk("burst_total_doorbells", tot, 16);
      chk("burst_pending_end", pending, 0);
      chk("burst_busy_end", busy, 0);

      // doorbell with fetch handshake; irq_clr during DOORBELL
      irq_enable = 1'b1;
      ring();
      run_job(1, 16'h0, 1'b0, 1'b1, 1'b1, fa, ca, ndb, ph);
      chk("simul_pending", ph, 1);
      chk("simul_fetch_addr", fa, 64'h140);
      chk("simul_cwr_addr", ca, 64'h510);
      chk("simul_irq_set_wins", irq, 1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("irq_clr", irq, 0);
      run_job(0, 16'h0, 1'b0, 1'b0, 1'b0, fa, ca, ndb, ph);
      chk("job_b_fetch_addr", fa, 64'h180);
      chk("job_b_cwr_addr", ca, 64'h520);
      chk("job_b_irq", irq, 1);
      chk("job_b_pending", pending, 0);
      irq_enable = 1'b0;
      @(negedge clk);
      chk("irq_sticky_after_disable", irq, 1);

      // reset mid-EXEC
      ring();
      t = 0;
      while (!fetch_valid && t < 40) begin @(negedge clk); t++; end
      chk("rst_exec_fetch_valid", fetch_valid, 1);
      fetch_ready = 1'b1;
      @(negedge clk);
      fetch_ready = 1'b0;
      chk("rst_exec_busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_exec_busy", busy, 0);
      chk("rst_exec_cwr_valid", cwr_valid, 0);
      chk("rst_exec_overflow", overflow, 0);
      chk("rst_exec_irq", irq, 0);
      chk("rst_exec_err_count", err_count, 0);
      chk("rst_exec_fetch_addr", fetch_addr, 0);
      chk("rst_exec_cwr_addr", cwr_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         if (comp_doorbell) tot++;
         @(negedge clk);
      end
      chk("rst_exec_no_doorbell", tot, 0);
      ring();
      run_job(0, 16'h0, 1'b0, 1'b0, 1'b0, fa, ca, ndb, ph);
      chk("post_rst_fetch_addr", fa, 64'h100);
      chk("post_rst_cwr_addr", ca, 64'h500);
      chk("post_rst_doorbells", ndb, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
